// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response and
// decode-side instruction handshake.
interface pc_fetch_unit_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ready,
    input  i_imem_rvalid,
    input  i_imem_rdata,
    output o_inst_valid,
    output o_inst,
    output o_inst_pc,
    input  i_inst_ready
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ready,
    output i_imem_rvalid,
    output i_imem_rdata,
    input  o_inst_valid,
    input  o_inst,
    input  o_inst_pc,
    output i_inst_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch with
// redirect handling and stale-response dropping.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  pc_fetch_unit_if.master bus,
  output logic        o_misaligned,
  output logic [31:0] o_fetch_count
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DROP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    mis_d     = i_redirect && (i_redirect_pc[1:0] != 2'b00);
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.i_imem_ready)
          state_d = i_redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (bus.i_imem_rvalid) begin
          if (i_redirect) begin
            state_d = REQ;
          end else begin
            inst_d    = bus.i_imem_rdata;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (i_redirect) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (i_redirect) begin
          state_d = REQ;
        end else if (bus.i_inst_ready) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
          state_d = REQ;
        end
      end
      DROP: begin
        // exactly one in-flight response is owed; swallow it
        if (bus.i_imem_rvalid)
          state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (i_redirect)
      pc_d = {i_redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      cnt_q     <= 32'h0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.o_imem_req   = (state_q == REQ);
  assign bus.o_imem_addr  = pc_q;
  assign bus.o_inst_valid = (state_q == HOLD);
  assign bus.o_inst       = inst_q;
  assign bus.o_inst_pc    = inst_pc_q;
  assign o_misaligned     = mis_q;
  assign o_fetch_count    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with an address-derived
// instruction memory of configurable response latency.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic [31:0] fetch_count;

  int errors;
  int checks;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .bus           (bus),
    .o_misaligned  (misaligned),
    .o_fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h1357_2468;
  endfunction

  // memory responder: one response, lat cycles after the first
  int          lat;
  logic        mem_rdy;
  logic        pend;
  logic [31:0] paddr;
  int          cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (bus.o_imem_req && mem_rdy) begin
      pend  <= 1'b1;
      paddr <= bus.o_imem_addr;
      cnt   <= lat;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  assign bus.i_imem_ready  = mem_rdy;
  assign bus.i_imem_rvalid = pend && (cnt == 0);
  assign bus.i_imem_rdata  = dat(paddr);

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.o_inst_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.o_inst_valid) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: inst_valid=%0b required 1", nm,
               bus.o_inst_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.o_imem_req !== 1'b0 || bus.o_inst_valid !== 1'b0 ||
        bus.o_inst !== 32'h0 || bus.o_inst_pc !== 32'h0 ||
        misaligned !== 1'b0 || fetch_count !== 32'h0 ||
        bus.o_imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b v=%b inst=%h pc=%h mis=%b cnt=%0d addr=%h required all 0",
               bus.o_imem_req, bus.o_inst_valid, bus.o_inst,
               bus.o_inst_pc, misaligned, fetch_count, bus.o_imem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    for (int k = 1; k <= 9; k++) begin
      step();
      ea = 32'((k - 1) / 3 * 4);
      checks++;
      if (bus.o_inst_valid !== (k % 3 == 0)) begin
        errors++;
        $display("FAIL stream_valid k=%0d: got %b required %b", k,
                 bus.o_inst_valid, (k % 3 == 0));
      end
      if (k % 3 == 1) begin
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== ea) begin
          errors++;
          $display("FAIL stream_addr k=%0d: req=%b addr=%h required 1 %h",
                   k, bus.o_imem_req, bus.o_imem_addr, ea);
        end
      end
      if (k % 3 == 0) begin
        checks++;
        if (bus.o_inst !== dat(ea) || bus.o_inst_pc !== ea) begin
          errors++;
          $display("FAIL stream_inst k=%0d: inst=%h pc=%h required %h %h",
                   k, bus.o_inst, bus.o_inst_pc, dat(ea), ea);
        end
      end
    end
    step();
    checks++;
    if (fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL stream_count: got %0d required 3", fetch_count);
    end
  endtask

  task automatic test_backpressure();
    bus.i_inst_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== dat(32'd12) ||
          bus.o_inst_pc !== 32'd12 || bus.o_imem_req !== 1'b0 ||
          fetch_count !== 32'd3) begin
        errors++;
        $display("FAIL backpressure i=%0d: v=%b inst=%h pc=%h req=%b cnt=%0d required 1 %h 0000000c 0 3",
                 i, bus.o_inst_valid, bus.o_inst, bus.o_inst_pc,
                 bus.o_imem_req, fetch_count, dat(32'd12));
      end
      step();
    end
    bus.i_inst_ready = 1'b1;
    step();
    checks++;
    if (fetch_count !== 32'd4 || bus.o_imem_addr !== 32'd16) begin
      errors++;
      $display("FAIL backpressure_release: cnt=%0d addr=%h required 4 00000010",
               fetch_count, bus.o_imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    lat = 3;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    lat      = 0;
    n        = 0;
    while (!bus.o_imem_req && n < 20) begin
      checks++;
      if (bus.o_inst === dat(32'd16) || bus.o_inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_drop: inst=%h v=%b required not %h and 0",
                 bus.o_inst, bus.o_inst_valid, dat(32'd16));
      end
      step();
      n++;
    end
    checks++;
    if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_wait_addr: req=%b addr=%h required 1 00000100",
               bus.o_imem_req, bus.o_imem_addr);
    end
    wait_valid("redirect_wait_valid");
    checks++;
    if (bus.o_inst_pc !== 32'h100 || bus.o_inst !== dat(32'h100) ||
        fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL redirect_wait_inst: pc=%h inst=%h cnt=%0d required 00000100 %h 4",
               bus.o_inst_pc, bus.o_inst, fetch_count, dat(32'h100));
    end
    step();
  endtask

  task automatic test_redirect_accept_hold();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    checks++;
    if (bus.o_imem_req !== 1'b0 || bus.o_imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL accept_drop: req=%b addr=%h required 0 00000200",
               bus.o_imem_req, bus.o_imem_addr);
    end
    step();
    checks++;
    if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL accept_resume: req=%b addr=%h required 1 00000200",
               bus.o_imem_req, bus.o_imem_addr);
    end
    bus.i_inst_ready = 1'b0;
    wait_valid("accept_valid");
    checks++;
    if (bus.o_inst_pc !== 32'h200 || fetch_count !== 32'd5) begin
      errors++;
      $display("FAIL accept_inst: pc=%h cnt=%0d required 00000200 5",
               bus.o_inst_pc, fetch_count);
    end
    bus.i_inst_ready = 1'b1;
    redirect         = 1'b1;
    redirect_pc      = 32'h300;
    step();
    redirect = 1'b0;
    checks++;
    if (fetch_count !== 32'd5 || bus.o_inst_valid !== 1'b0 ||
        bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h300 ||
        misaligned !== 1'b0) begin
      errors++;
      $display("FAIL hold_redirect: cnt=%0d v=%b req=%b addr=%h mis=%b required 5 0 1 00000300 0",
               fetch_count, bus.o_inst_valid, bus.o_imem_req,
               bus.o_imem_addr, misaligned);
    end
    wait_valid("hold_valid");
    checks++;
    if (bus.o_inst_pc !== 32'h300 || bus.o_inst !== dat(32'h300)) begin
      errors++;
      $display("FAIL hold_resume: pc=%h inst=%h required 00000300 %h",
               bus.o_inst_pc, bus.o_inst, dat(32'h300));
    end
    step();
    checks++;
    if (fetch_count !== 32'd6) begin
      errors++;
      $display("FAIL hold_count: got %0d required 6", fetch_count);
    end
  endtask

  task automatic test_misaligned();
    mem_rdy     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h206;
    step();
    redirect = 1'b0;
    checks++;
    if (misaligned !== 1'b1 || bus.o_imem_req !== 1'b1 ||
        bus.o_imem_addr !== 32'h204) begin
      errors++;
      $display("FAIL misaligned_pulse: mis=%b req=%b addr=%h required 1 1 00000204",
               misaligned, bus.o_imem_req, bus.o_imem_addr);
    end
    step();
    checks++;
    if (misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_width: got %b required 0", misaligned);
    end
    mem_rdy = 1'b1;
    wait_valid("misaligned_valid");
    checks++;
    if (bus.o_inst_pc !== 32'h204) begin
      errors++;
      $display("FAIL misaligned_inst_pc: got %h required 00000204",
               bus.o_inst_pc);
    end
    step();
  endtask

  task automatic test_wrap();
    mem_rdy     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    mem_rdy  = 1'b1;
    wait_valid("wrap_valid");
    checks++;
    if (bus.o_inst_pc !== 32'hFFFF_FFFC ||
        bus.o_inst !== dat(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_inst: pc=%h inst=%h required fffffffc %h",
               bus.o_inst_pc, bus.o_inst, dat(32'hFFFF_FFFC));
    end
    step();
    checks++;
    if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0 ||
        fetch_count !== 32'd8) begin
      errors++;
      $display("FAIL wrap_addr: req=%b addr=%h cnt=%0d required 1 00000000 8",
               bus.o_imem_req, bus.o_imem_addr, fetch_count);
    end
  endtask

  task automatic test_async_reset();
    wait_valid("pre_reset_valid");
    step();
    lat = 3;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_imem_req !== 1'b0 || bus.o_inst_valid !== 1'b0 ||
        bus.o_inst !== 32'h0 || bus.o_inst_pc !== 32'h0 ||
        misaligned !== 1'b0 || fetch_count !== 32'h0 ||
        bus.o_imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b v=%b inst=%h pc=%h mis=%b cnt=%0d addr=%h required all 0",
               bus.o_imem_req, bus.o_inst_valid, bus.o_inst,
               bus.o_inst_pc, misaligned, fetch_count, bus.o_imem_addr);
    end
    lat = 0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL restart_addr: req=%b addr=%h required 1 00000000",
               bus.o_imem_req, bus.o_imem_addr);
    end
    wait_valid("restart_valid");
    checks++;
    if (bus.o_inst_pc !== 32'h0 || bus.o_inst !== dat(32'h0) ||
        fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL restart_inst: pc=%h inst=%h cnt=%0d required 00000000 %h 0",
               bus.o_inst_pc, bus.o_inst, fetch_count, dat(32'h0));
    end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    rst              = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = 32'h0;
    mem_rdy          = 1'b1;
    lat              = 0;
    bus.i_inst_ready = 1'b1;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_accept_hold();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
